// File: rtl/mem_port_sched.sv
// mem_port_sched: byte-serial scheduler for the single 8-bit external memory port.
//
// Shares the port between the instruction fetcher (INF, FETCH_LEN-byte reads)
// and the data cache (DC, 1/2/4-byte loads and stores). Each request becomes
// one bus cycle per byte. Read bytes are assembled little-endian and store
// words are split the same way. Stores to the IO window stall while the UART
// buffer is full.
//
// Ports:
//   clk, rst (async, active-low), rdy (low = pause), clr (pipeline flush)
//   iIO_buffer_full           UART buffer full, gates IO store bytes
//   iMEM_dt / oMEM_dt         memory read byte / write byte
//   oMEM_rw, oMEM_addr        write strobe and byte address
//   iINF_* / oINF_*           fetch request (level) and completion pulse + word
//   iDC_* / oDC_*             data request (level) and completion pulse + load data
//
// Build option: define MEM_SCHED_RR_EN for round-robin arbitration between
// simultaneous INF and DC requests. Without it, DC always wins.
module mem_port_sched #(
  parameter logic [1:0] IO_SEL    = 2'b11,
  parameter int         FETCH_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        iIO_buffer_full,
  input  logic [7:0]  iMEM_dt,
  output logic        oMEM_rw,
  output logic [31:0] oMEM_addr,
  output logic [7:0]  oMEM_dt,
  input  logic        iINF_en,
  input  logic [31:0] iINF_addr,
  output logic        oINF_done,
  output logic [31:0] oINF_inst,
  input  logic        iDC_en,
  input  logic        iDC_ls,
  input  logic [2:0]  iDC_len,
  input  logic [31:0] iDC_addr,
  input  logic [31:0] iDC_dt,
  output logic        oDC_done,
  output logic [31:0] oDC_dt
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;          // RD: edges since grant; WR: bytes issued
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic        owner_q, owner_d;      // 1 = DC owns the transfer
  logic        io_q, io_d;
  logic [31:0] data_q, data_d;
  logic [31:0] buf_q, buf_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        inf_done_q, inf_done_d;
  logic [31:0] inf_inst_q, inf_inst_d;
  logic        dc_done_q, dc_done_d;
  logic [31:0] dc_dt_q, dc_dt_d;
`ifdef MEM_SCHED_RR_EN
  logic        hist_q, hist_d;        // 1 = DC was granted last
`endif

  logic        inf_req, dc_req, pick_dc, dc_io, dc_gated;
  logic [1:0]  rd_idx, wr_idx;
  logic [31:0] buf_n, rd_result;

  // A fetch raised during a flush is stale and must not win the port.
  assign inf_req  = iINF_en & ~clr;
  assign dc_req   = iDC_en;
  assign dc_io    = (iDC_addr[17:16] == IO_SEL);
  assign dc_gated = dc_io & iIO_buffer_full;
`ifdef MEM_SCHED_RR_EN
  assign pick_dc  = dc_req & (~inf_req | ~hist_q);
`else
  assign pick_dc  = dc_req;
`endif

  // Read data lags its address by one cycle, so the byte arriving now
  // belongs to the address issued on the previous edge (cnt_q - 1).
  assign rd_idx    = cnt_q[1:0] - 2'd1;
  assign wr_idx    = cnt_q[1:0];
  always_comb begin
    buf_n = buf_q;
    buf_n[{rd_idx, 3'b000} +: 8] = iMEM_dt;
  end
  assign rd_result = (cnt_q != 3'd0) ? buf_n : buf_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    owner_d    = owner_q;
    io_d       = io_q;
    data_d     = data_q;
    buf_d      = buf_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    inf_done_d = inf_done_q;
    inf_inst_d = inf_inst_q;
    dc_done_d  = dc_done_q;
    dc_dt_d    = dc_dt_q;
`ifdef MEM_SCHED_RR_EN
    hist_d     = hist_q;
`endif
    // rdy low freezes every register; only the visible write strobe is masked.
    if (rdy) begin
      rw_d       = 1'b0;
      inf_done_d = 1'b0;
      dc_done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inf_req | dc_req) begin
            owner_d = pick_dc;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
`ifdef MEM_SCHED_RR_EN
            hist_d  = pick_dc;
`endif
            if (pick_dc) begin
              base_d = iDC_addr;
              len_d  = iDC_len;
              data_d = iDC_dt;
              io_d   = dc_io;
              if (iDC_ls) begin
                state_d = S_WR;
                // Byte 0 goes out on the grant edge unless the UART is full.
                if (!dc_gated && iDC_len != 3'd0) begin
                  rw_d   = 1'b1;
                  addr_d = iDC_addr;
                  dout_d = iDC_dt[7:0];
                  cnt_d  = 3'd1;
                end
              end else begin
                state_d = S_RD;
                addr_d  = iDC_addr;
              end
            end else begin
              base_d  = iINF_addr;
              len_d   = 3'(FETCH_LEN);
              io_d    = 1'b0;
              state_d = S_RD;
              addr_d  = iINF_addr;
            end
          end
        end
        S_RD: begin
          if (clr) begin
            state_d = S_IDLE;
          end else begin
            if (cnt_q != 3'd0) buf_d = buf_n;
            if (cnt_q == len_q) begin
              state_d = S_DONE;
              if (owner_q) begin
                dc_done_d = 1'b1;
                dc_dt_d   = rd_result;
              end else begin
                inf_done_d = 1'b1;
                inf_inst_d = rd_result;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              if ((cnt_q + 3'd1) < len_q) addr_d = base_q + 32'(cnt_q + 3'd1);
            end
          end
        end
        S_WR: begin
          if (cnt_q == len_q) begin
            state_d   = S_DONE;
            dc_done_d = 1'b1;
          end else if (!(io_q && iIO_buffer_full)) begin
            rw_d   = 1'b1;
            addr_d = base_q + 32'(cnt_q);
            dout_d = data_q[{wr_idx, 3'b000} +: 8];
            cnt_d  = cnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;   // S_DONE: one cycle so the requester can drop en
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      base_q     <= 32'd0;
      owner_q    <= 1'b0;
      io_q       <= 1'b0;
      data_q     <= 32'd0;
      buf_q      <= 32'd0;
      rw_q       <= 1'b0;
      addr_q     <= 32'd0;
      dout_q     <= 8'd0;
      inf_done_q <= 1'b0;
      inf_inst_q <= 32'd0;
      dc_done_q  <= 1'b0;
      dc_dt_q    <= 32'd0;
`ifdef MEM_SCHED_RR_EN
      hist_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      owner_q    <= owner_d;
      io_q       <= io_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      inf_done_q <= inf_done_d;
      inf_inst_q <= inf_inst_d;
      dc_done_q  <= dc_done_d;
      dc_dt_q    <= dc_dt_d;
`ifdef MEM_SCHED_RR_EN
      hist_q     <= hist_d;
`endif
    end
  end

  assign oMEM_rw   = rw_q & rdy;
  assign oMEM_addr = addr_q;
  assign oMEM_dt   = dout_q;
  assign oINF_done = inf_done_q;
  assign oINF_inst = inf_inst_q;
  assign oDC_done  = dc_done_q;
  assign oDC_dt    = dc_dt_q;

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Byte-serial scheduler for the single 8-bit external memory port.
- Shares the port between two requesters: instruction fetcher (INF, 4-byte reads) and data cache (DC, 1/2/4-byte loads and stores).
- Serializes each request into per-byte bus cycles, assembles or splits little-endian words, and stalls UART writes while the IO buffer is full.
- Sits between fetcher/dcache and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO access.
- FETCH_LEN, 4, bytes per instruction fetch.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; low = pause
- clr  in  1  pipeline flush from ROB
- iIO_buffer_full  in  1  UART buffer full
- iMEM_dt  in  8  memory read byte
- oMEM_rw  out  1  1 = write
- oMEM_addr  out  32  byte address
- oMEM_dt  out  8  write byte
- iINF_en  in  1  fetch request; level, held until done
- iINF_addr  in  32  fetch address
- oINF_done  out  1  one-cycle fetch completion pulse
- oINF_inst  out  32  fetched word
- iDC_en  in  1  data request; level, held until done
- iDC_ls  in  1  0 = load, 1 = store
- iDC_len  in  3  byte count: 1, 2 or 4
- iDC_addr  in  32  data address
- iDC_dt  in  32  store data (low len bytes used)
- oDC_done  out  1  one-cycle data completion pulse
- oDC_dt  out  32  load result, zero-extended

Behaviour:
- Reset (rst=0, async): state IDLE, cnt=0, grant-history bit=0. oMEM_rw=0, oMEM_addr=0, oMEM_dt=0, oINF_done=0, oINF_inst=0, oDC_done=0, oDC_dt=0.
- States:
  - IDLE -> RD (INF, or DC load) or WR (DC store), on grant.
  - RD -> DONE after final byte captured.
  - WR -> DONE after final byte issued.
  - DONE -> IDLE unconditionally.
- Grant:
  - Sampled in IDLE only.
  - Request latched: base addr, len (INF: FETCH_LEN), owner, store data.
  - INF request while clr=1 is not granted.
- RD timing:
  - Byte k address (base+k) driven on oMEM_addr in cycle k+1 after the grant edge.
  - Its data is captured from iMEM_dt one cycle later into bits [8k+7:8k].
  - For N bytes: done pulse is high in cycle N+2 after the grant edge, with result valid in the same cycle.
  - Unused upper bytes are 0.
- WR timing:
  - Byte k = iDC_dt[8k+7:8k] to base+k, oMEM_rw=1, one cycle per byte.
  - oDC_done high the cycle after the last byte.
- IO store (addr[17:16]==IO_SEL):
  - While iIO_buffer_full=1, no byte is issued: oMEM_rw=0, cnt held.
  - Issue resumes the cycle after it drops.
  - IO loads are not gated.
- Idle bus: oMEM_rw=0 in every cycle not issuing a write byte; oMEM_addr holds its last value.
- Done handshake:
  - done is a one-cycle pulse.
  - Requester drops en in the cycle after done.
  - DONE state guarantees no regrant of the stale request.
- clr=1:
  - An in-flight INF read is abandoned: state -> IDLE next edge, no oINF_done.
  - A DC load is likewise abandoned.
  - A DC store always completes; clr is ignored for it.
- rdy=0: all registers hold; oMEM_rw is combinationally forced 0; the write byte is reissued on resume.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- Simultaneous iINF_en and iDC_en in IDLE: resolved per Optional Feature.

Optional Feature:
- Macro: MEM_SCHED_RR_EN.
- Defined: round-robin arbitration.
  - On a conflict, grant goes to the requester not granted last; the history bit updates on every grant.
  - A lone request is granted regardless of history.
- Undefined: fixed priority, DC always beats INF; the history bit is absent.

Test Plan:
- Fetch: iINF_en=1, addr 0x00000100, memory bytes 13 05 00 00 -> addresses 0x100..0x103 issued on consecutive cycles; oINF_inst=0x00000513; oINF_done pulses exactly once, 6 cycles after the grant edge.
- Store halfword: iDC_ls=1, len=2, addr 0x00001002, dt=0xDEADBEEF -> writes 0xEF@0x1002, then 0xBE@0x1003, oMEM_rw=1 for 2 cycles; oDC_done pulses once; memory 0x1004 untouched.
- Byte load: mem[0x2000]=0x80, len=1 -> oDC_dt=0x00000080 (zero-extended).
- UART: store len=1 to 0x00030000 dt=0x41 with iIO_buffer_full=1 for 5 cycles -> oMEM_rw stays 0 for those cycles; 0x41 written the cycle after full drops.
- Conflict: both requests asserted in IDLE twice in a row -> without macro, DC, DC; with MEM_SCHED_RR_EN and last grant=DC, INF then DC.
- Flush/reset: clr=1 during byte 2 of a fetch -> no oINF_done, IDLE next cycle. rst=0 mid-store -> all outputs 0 immediately (async).
